// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: display data inputs and scanned segment/digit outputs
// for the multiplexed seven-segment driver. The master side supplies digit
// values and control; the slave side (the driver) returns the scan outputs.
interface seg_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;
    logic                  frame;

    modport master (
        output data, dp_in, load, blank_lz,
        input  seg, dp, an, frame
    );

    modport slave (
        input  data, dp_in, load, blank_lz,
        output seg, dp, an, frame
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment display driver.
// A prescaler holds each digit for SCAN_DIV clocks, then the digit index
// steps through 0..N_DIGITS-1. Segment, decimal point, digit enable and frame
// outputs are registered from the current index and display registers.
// Optional feature macro: SEG_HEX_EN -- when defined, values 10..15 show hex
// glyphs A b C d E F; when undefined they all show the error glyph.
module seg_scan_driver #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 1000
) (
    input logic         clk,
    input logic         rst,
    seg_scan_driver_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [PW-1:0]         prescaler;
    logic [IW-1:0]         index;
    logic [4*N_DIGITS-1:0] data_reg;
    logic [N_DIGITS-1:0]   dp_reg;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [N_DIGITS-1:0]   an_q;
    logic                  frame_q;

    logic                  advance;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [N_DIGITS-1:0]   an_next;
    logic [N_DIGITS-1:0]   blank_mask;
    logic                  zero_run;

    // Digit value to segments {a,b,c,d,e,f,g}; 10..15 depend on SEG_HEX_EN.
    function automatic logic [6:0] decode(input logic [3:0] value);
        case (value)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
`ifdef SEG_HEX_EN
            4'd10:   decode = 7'b1110111;
            4'd11:   decode = 7'b0011111;
            4'd12:   decode = 7'b1001110;
            4'd13:   decode = 7'b0111101;
            4'd14:   decode = 7'b1001111;
            default: decode = 7'b1000111;
`else
            default: decode = 7'b1001111;
`endif
        endcase
    endfunction

    // Terminal count of the prescaler ends the current digit's dwell.
    always_comb begin
        advance = (prescaler == PRE_LAST);
    end

    // Select the active digit's nibble, decimal point and blanking state;
    // a digit is blankable when it and everything above it are zero.
    always_comb begin
        cur_nibble = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        an_next    = '0;
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && (data_reg[4*k +: 4] == 4'd0);
            blank_mask[k] = zero_run;
        end
        for (int k = 0; k < N_DIGITS; k++) begin
            if (index == IW'(k)) begin
                cur_nibble = data_reg[4*k +: 4];
                cur_dp     = dp_reg[k];
                an_next[k] = 1'b1;
                cur_blank  = blank_mask[k] && (k != 0);
            end
        end
    end

    // Prescaler and digit index; the index steps only at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            index     <= '0;
        end else if (advance) begin
            prescaler <= '0;
            index     <= (index == IDX_LAST) ? '0 : index + IW'(1);
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Display registers capture new values on load, independent of the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            dp_reg   <= '0;
        end else if (bus.load) begin
            data_reg <= bus.data;
            dp_reg   <= bus.dp_in;
        end
    end

    // Registered outputs; frame marks the cycle the enable wraps top -> digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q   <= '0;
            dp_q    <= 1'b0;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= (bus.blank_lz && cur_blank) ? 7'b0000000 : decode(cur_nibble);
            dp_q    <= cur_dp;
            an_q    <= an_next;
            frame_q <= (prescaler == '0) && (index == '0) && an_q[N_DIGITS-1];
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver with
// N_DIGITS=4, SCAN_DIV=4. Hex expectations follow the SEG_HEX_EN macro.
module tb_seg_scan_driver;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   n;

    logic [6:0] exp_seg_tab [4];
    logic       exp_dp_tab  [4];

    seg_scan_driver_if #(.N_DIGITS(4)) bus ();

    seg_scan_driver #(
        .N_DIGITS(4),
        .SCAN_DIV(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_dp,
                             input logic exp_frame);
        check_output($sformatf("%s n=%0d an", tag, n), 32'(bus.an), 32'(exp_an));
        check_output($sformatf("%s n=%0d seg", tag, n), 32'(bus.seg), 32'(exp_seg));
        check_output($sformatf("%s n=%0d dp", tag, n), 32'(bus.dp), 32'(exp_dp));
        check_output($sformatf("%s n=%0d frame", tag, n), 32'(bus.frame), 32'(exp_frame));
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    // Output after edge n shows digit ((n-1)/4)%4; frame on n = 17, 33, ...
    task automatic run_scan(input string tag, input int count);
        int   digit;
        logic frame_exp;
        for (int i = 0; i < count; i++) begin
            step();
            digit     = ((n - 1) / 4) % 4;
            frame_exp = (n > 1) && (((n - 1) % 16) == 0);
            check_all(tag, 4'(1 << digit), exp_seg_tab[digit], exp_dp_tab[digit], frame_exp);
        end
    endtask

    task automatic set_tables(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dps);
        exp_seg_tab[3] = s3;
        exp_seg_tab[2] = s2;
        exp_seg_tab[1] = s1;
        exp_seg_tab[0] = s0;
        for (int k = 0; k < 4; k++) exp_dp_tab[k] = dps[k];
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b0;
        checks       = 0;
        failures     = 0;
        n            = 0;
        bus.data     = '0;
        bus.dp_in    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;

        // Reset applies immediately and holds across edges.
        #1 rst = 1'b1;
        #1 check_all("reset_async", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        step();
        step();
        check_all("reset_hold", 4'b0000, 7'b0000000, 1'b0, 1'b0);

        // First edge after release shows digit 0 with decode(0).
        rst = 1'b0;
        n   = 0;
        step();
        check_all("first_edge", 4'b0001, 7'b1111110, 1'b0, 1'b0);

        // Load 1234: edge 2 still shows old data, then a full scan with dwell 4.
        bus.data = 16'h1234;
        bus.load = 1'b1;
        set_tables(7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b0000);
        run_scan("load_edge", 1);
        bus.load = 1'b0;
        set_tables(7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 4'b0000);
        run_scan("scan_1234", 31);

        // Leading-zero blanking of 0070.
        bus.blank_lz = 1'b1;
        bus.data     = 16'h0070;
        bus.load     = 1'b1;
        run_scan("blank_load", 1);
        bus.load = 1'b0;
        set_tables(7'b0000000, 7'b0000000, 7'b1110000, 7'b1111110, 4'b0000);
        run_scan("blank_on", 16);
        bus.blank_lz = 1'b0;
        set_tables(7'b1111110, 7'b1111110, 7'b1110000, 7'b1111110, 4'b0000);
        run_scan("blank_off", 16);

        // Values A and F with the decimal point on digit 1.
        bus.data  = 16'h00AF;
        bus.dp_in = 4'b0010;
        bus.load  = 1'b1;
        run_scan("hex_load", 1);
        bus.load = 1'b0;
`ifdef SEG_HEX_EN
        set_tables(7'b1111110, 7'b1111110, 7'b1110111, 7'b1000111, 4'b0010);
`else
        set_tables(7'b1111110, 7'b1111110, 7'b1001111, 7'b1001111, 4'b0010);
`endif
        run_scan("hex_af", 16);
        run_scan("to_mid_dwell", 7);

        // n=90: digit 2, second cycle of its dwell; reset clears outputs at once.
        bus.dp_in = 4'b0000;
        rst       = 1'b1;
        #1 check_all("reset_mid_async", 4'b0000, 7'b0000000, 1'b0, 1'b0);
        step();
        step();
        check_all("reset_mid_hold", 4'b0000, 7'b0000000, 1'b0, 1'b0);

        // Scan restarts at digit 0 with full dwell and cleared registers.
        rst = 1'b0;
        n   = 0;
        set_tables(7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b0000);
        run_scan("restart", 7);

        // Load 9999 on the advance edge (edge 8): edge 9 shows digit 2 with 9.
        bus.data = 16'h9999;
        bus.load = 1'b1;
        run_scan("advance_load", 1);
        bus.load = 1'b0;
        set_tables(7'b1111011, 7'b1111011, 7'b1111011, 7'b1111011, 4'b0000);
        run_scan("after_advance", 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 1000, clock cycles each digit is held; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data  input  4*N_DIGITS  nibble k (bits 4k+3:4k) is the value for digit k; digit 0 is least significant.
REQ-006 dp_in  input  N_DIGITS  decimal point request per digit.
REQ-007 load  input  1  capture data and dp_in into the display registers.
REQ-008 blank_lz  input  1  leading-zero blanking enable, sampled every cycle.
REQ-009 seg  output  7  segments {a,b,c,d,e,f,g}, active-high.
REQ-010 dp  output  1  decimal point of the active digit, active-high.
REQ-011 an  output  N_DIGITS  one-hot digit enable, active-high.
REQ-012 frame  output  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

Function
REQ-013 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the digit index SHALL advance, wrapping N_DIGITS-1 -> 0.
REQ-014 load=1 at an edge SHALL update data_reg and dp_reg at that edge without disturbing the prescaler or the index.
REQ-015 seg, dp, an and frame SHALL be registered outputs computed from the current index, data_reg, dp_reg and blank_lz, giving 1-cycle latency.
REQ-016 Decode table, a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-017 Values 10..15 SHALL follow REQ-032.
REQ-018 With blank_lz=1, a digit SHALL be blanked (seg=0000000) when it and every more-significant digit are zero.
REQ-019 Digit 0 SHALL never be blanked.
REQ-020 dp SHALL equal dp_reg[index] regardless of blanking.
REQ-021 frame SHALL be 1 for exactly the one cycle in which an changes from bit N_DIGITS-1 to bit 0.
REQ-022 When load coincides with an index advance, both SHALL take effect, and the next output SHALL show the new data at the new index.
REQ-023 With N_DIGITS=1, an SHALL be constant 1 after the first edge, and frame SHALL pulse once every SCAN_DIV cycles.

Reset
REQ-024 While rst=1: prescaler=0, index=0, data_reg=0, dp_reg=0, seg=0, dp=0, an=0, frame=0, applied immediately without waiting for clk.
REQ-025 The first edge after rst falls SHALL produce an=one-hot bit 0 and seg=decode(0)=1111110.
REQ-026 Reset asserted mid-scan SHALL discard the scan position, and the scan SHALL restart at digit 0 with a full SCAN_DIV dwell.

Configuration
REQ-027 Macro SEG_HEX_EN selects the hex-glyph feature.
REQ-028 With SEG_HEX_EN defined, value 10 (A) SHALL decode to 1110111.
REQ-029 With SEG_HEX_EN defined, value 11 (b) SHALL decode to 0011111, and value 12 (C) to 1001110.
REQ-030 With SEG_HEX_EN defined, value 13 (d) SHALL decode to 0111101, value 14 (E) to 1001111, and value 15 (F) to 1000111.
REQ-031 With SEG_HEX_EN defined, blanking SHALL test the value for zero only.
REQ-032 Without SEG_HEX_EN, values 10..15 SHALL all decode to the error glyph 1001111, and no hex decode logic SHALL be present.

Verification (N_DIGITS=4, SCAN_DIV=4)
REQ-033 Hold rst=1, then release -> all outputs are 0 during reset; after the first edge an=0001 and seg=1111110.
REQ-034 Load data=16'h1234 -> digit 0 shows seg=0110011, digit 1 shows 1111001, digit 2 shows 1101101, digit 3 shows 0110000; each digit is held 4 cycles; frame pulses once every 16 cycles.
REQ-035 Set blank_lz=1 and load 16'h0070 -> digits 3 and 2 show 0000000, digit 1 shows 1110000, digit 0 shows 1111110; with blank_lz=0, digits 3 and 2 show 1111110.
REQ-036 Load 16'h00AF with dp_in=4'b0010 -> with SEG_HEX_EN, digit 1 shows 1110111 and digit 0 shows 1000111; without SEG_HEX_EN, both show 1001111; dp=1 only while an=0010.
REQ-037 Assert rst at index 2 mid-dwell -> outputs go to 0 before the next edge; after release, the scan restarts at an=0001 with a 4-cycle dwell.
REQ-038 Pulse load with 16'h9999 on the index-advance edge -> the next cycle shows the new index with seg=1111011, and the prescaler phase is unchanged.
